// File: rtl/dp_fifo_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dp_fifo_pkg: shared widths and response-FSM states for dp_fifo_arbiter.   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package dp_fifo_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 31;
  localparam int REQ_W      = 1 + ADDR_W + DATA_W;
  localparam int TID_W      = 16;
  localparam int DP_DATA_W  = TID_W + REQ_W;
  localparam int VPI_DATA_W = TID_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    DELIVER = 2'd2
  } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick of the first request at or     |
// | after ptr_i (wrapping). Rev 1.0                                           |
// +---------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[pos]) begin
        valid_o      = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dp_fifo_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dp_fifo_arbiter: shares the DP->VPI request FIFO and VPI->DP serve FIFO   |
// | among NUM_REQ requesters, TID-tagged, with per-requester issue limits.    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module dp_fifo_arbiter
  import dp_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int TID_WIDTH  = TID_W,
  parameter int MAX_OUTST  = 4,
  parameter int REQ_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*REQ_WIDTH-1:0]    req_payload,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            fifo_wr_en,
  output logic [TID_WIDTH+REQ_WIDTH-1:0]  fifo_wr_data,
  input  logic                            fifo_full,
  output logic                            fifo_rd_en,
  input  logic [TID_WIDTH+DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                            fifo_empty,
  output logic                            err_bad_tid
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         outst_cnt_q [NUM_REQ];
  logic [CW-1:0]         outst_cnt_d [NUM_REQ];
  resp_state_t           state_q, state_d;
  logic [IW-1:0]         tid_q, tid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         winner;
  logic                  issue;
  logic [REQ_WIDTH-1:0]  sel_payload;
  logic                  deliver_hs;
  logic [TID_WIDTH-1:0]  rd_tid;
  logic [IW-1:0]         rd_idx;
  logic                  rd_tid_ok;
  logic                  rd_cnt_nz;

  // A full FIFO or active reset removes every candidate, so no grant can form.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (outst_cnt_q[i] < CW'(MAX_OUTST)) && !fifo_full && !rst;
    end
  end

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (winner),
    .valid_o (issue)
  );

  always_comb begin
    sel_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_payload = req_payload[i*REQ_WIDTH +: REQ_WIDTH];
      end
    end
  end

  assign req_ready    = grant;
  assign fifo_wr_en   = issue;
  assign fifo_wr_data = issue ? {TID_WIDTH'(winner), sel_payload} : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Any TID at or above NUM_REQ, including nonzero upper bits, is invalid.
  assign rd_tid    = fifo_rd_data[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
  assign rd_idx    = rd_tid[IW-1:0];
  assign rd_tid_ok = rd_tid < TID_WIDTH'(NUM_REQ);

  always_comb begin
    rd_cnt_nz = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_idx == IW'(i)) begin
        rd_cnt_nz = (outst_cnt_q[i] != '0);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tid_d      = tid_q;
    data_d     = data_q;
    err_d      = err_q;
    fifo_rd_en = 1'b0;
    resp_valid = '0;
    deliver_hs = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !rst) begin
          fifo_rd_en = 1'b1;
          state_d    = POP;
        end
      end
      POP: begin
        tid_d  = rd_idx;
        data_d = fifo_rd_data[DATA_WIDTH-1:0];
        if (rd_tid_ok && rd_cnt_nz) begin
          state_d = DELIVER;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DELIVER: begin
        resp_valid = NUM_REQ'(1) << tid_q;
        if (resp_ready[tid_q]) begin
          deliver_hs = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_data   = data_q;
  assign err_bad_tid = err_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      outst_cnt_d[i] = outst_cnt_q[i]
                     + CW'(issue && (winner == IW'(i)))
                     - CW'(deliver_hs && (tid_q == IW'(i)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      state_q  <= IDLE;
      tid_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      state_q  <= state_d;
      tid_q    <= tid_d;
      data_q   <= data_d;
      err_q    <= err_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_cnt_q[i] <= outst_cnt_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_fifo_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_dp_fifo_arbiter: directed and randomized self-checking bench.          |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_dp_fifo_arbiter;
  import dp_fifo_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid, req_ready, resp_valid, resp_ready;
  logic [N*REQ_W-1:0]    req_payload;
  logic [DATA_W-1:0]     resp_data;
  logic                  fifo_wr_en, fifo_full, fifo_rd_en, fifo_empty, err_bad_tid;
  logic [DP_DATA_W-1:0]  fifo_wr_data;
  logic [VPI_DATA_W-1:0] fifo_rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: outstanding counts, pointer, serve FIFO contents, in-flight entry.
  int                    m_cnt [N];
  int                    m_ptr;
  bit                    m_busy, m_deliv, m_err;
  logic [VPI_DATA_W-1:0] m_ent;
  logic [VPI_DATA_W-1:0] sq [$];

  always #5 clk = ~clk;

  dp_fifo_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DATA_W),
    .ADDR_WIDTH (ADDR_W),
    .TID_WIDTH  (TID_W),
    .MAX_OUTST  (MAXO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_payload  (req_payload),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .err_bad_tid  (err_bad_tid)
  );

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_busy = 0; m_deliv = 0; m_err = 0; m_ent = '0;
    sq.delete();
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
  endtask

  function automatic int exp_winner();
    if (fifo_full) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i] && m_cnt[i] < MAXO) return i;
    end
    return -1;
  endfunction

  function automatic bit ent_good(logic [VPI_DATA_W-1:0] e);
    int t = int'(e[VPI_DATA_W-1:DATA_W]);
    if (t >= N) return 1'b0;
    return m_cnt[t] != 0;
  endfunction

  task automatic push(logic [VPI_DATA_W-1:0] e);
    sq.push_back(e);
    fifo_empty = 1'b0;
  endtask

  // Advance one clock, updating the model from pre-edge conditions.
  task automatic tick();
    int w, t;
    bit rd, hs, good;
    w    = exp_winner();
    rd   = !m_busy && (sq.size() != 0);
    t    = int'(m_ent[VPI_DATA_W-1:DATA_W]);
    hs   = m_deliv ? resp_ready[t] : 1'b0;
    good = m_busy && !m_deliv && ent_good(m_ent);
    @(posedge clk);
    if (w >= 0) begin m_cnt[w]++; m_ptr = (w + 1) % N; end
    if (m_deliv) begin
      if (hs) begin m_cnt[t]--; m_busy = 0; m_deliv = 0; end
    end else if (m_busy) begin
      if (good) m_deliv = 1;
      else begin m_err = 1; m_busy = 0; end
    end else if (rd) begin
      m_ent = sq.pop_front();
      m_busy = 1;
    end
    #1;
    fifo_rd_data = m_ent;
    fifo_empty   = (sq.size() == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; resp_ready = '0; fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1; resp_ready = '1; fifo_full = 1'b0; fifo_empty = 1'b0;
    req_payload = '1; fifo_rd_data = '1;
    @(posedge clk); #2;
    n_checks++; if (req_ready !== '0)    $display("FAIL rst_req_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (fifo_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", fifo_wr_en); else n_pass++;
    n_checks++; if (fifo_wr_data !== '0) $display("FAIL rst_wr_data: got %h want 0", fifo_wr_data); else n_pass++;
    n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
    n_checks++; if (resp_valid !== '0)   $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== '0)    $display("FAIL rst_resp_data: got %h want 0", resp_data); else n_pass++;
    n_checks++; if (err_bad_tid !== 1'b0) $display("FAIL rst_err: got %b want 0", err_bad_tid); else n_pass++;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL empty_rd_en c%0d: got %b want 0", k, fifo_rd_en); else n_pass++;
      tick();
    end
  endtask

  task automatic test_single();
    logic [REQ_W-1:0] p;
    do_reset();
    p = {1'b1, 31'h10, 32'hAB};
    req_payload = '0;
    req_payload[REQ_W-1:0] = p;
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else n_pass++;
    n_checks++; if (fifo_wr_en !== 1'b1)   $display("FAIL single_wr_en: got %b want 1", fifo_wr_en); else n_pass++;
    n_checks++; if (fifo_wr_data !== {16'h0000, p}) $display("FAIL single_wr_data: got %h want %h", fifo_wr_data, {16'h0000, p}); else n_pass++;
    tick();
    req_valid = '0;
  endtask

  task automatic test_issue_limit();
    do_reset();
    req_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] exp;
      exp = (k < MAXO) ? 4'b0001 : 4'b0000;
      #1;
      n_checks++; if (req_ready !== exp) $display("FAIL limit_ready c%0d: got %b want %b", k, req_ready, exp); else n_pass++;
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      logic [N-1:0] exp;
      exp = (k < N * MAXO) ? (4'b0001 << (k % N)) : 4'b0000;
      #1;
      n_checks++; if (req_ready !== exp) $display("FAIL rr_order c%0d: got %b want %b", k, req_ready, exp); else n_pass++;
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    req_valid = 4'b0001;
    #1 tick();
    req_valid = 4'b1111; fifo_full = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL full_ready c%0d: got %b want 0000", k, req_ready); else n_pass++;
      n_checks++; if (fifo_wr_en !== 1'b0)   $display("FAIL full_wr_en c%0d: got %b want 0", k, fifo_wr_en); else n_pass++;
      tick();
    end
    fifo_full = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL full_resume: got %b want 0010", req_ready); else n_pass++;
    tick();
    req_valid = '0;
  endtask

  task automatic test_response();
    do_reset();
    req_valid = 4'b0100;
    #1 tick();
    req_valid = '0;
    push({16'd2, 32'h55});
    #1;
    n_checks++; if (fifo_rd_en !== 1'b1) $display("FAIL resp_rd_pulse: got %b want 1", fifo_rd_en); else n_pass++;
    tick(); #1;
    n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL resp_rd_single: got %b want 0", fifo_rd_en); else n_pass++;
    n_checks++; if (resp_valid !== 4'b0000) $display("FAIL resp_early: got %b want 0000", resp_valid); else n_pass++;
    tick(); #1;
    n_checks++; if (resp_valid !== 4'b0100) $display("FAIL resp_valid: got %b want 0100", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== 32'h55)   $display("FAIL resp_data: got %h want 55", resp_data); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      n_checks++; if (resp_valid !== 4'b0100 || resp_data !== 32'h55)
        $display("FAIL resp_hold c%0d: got %b/%h want 0100/55", k, resp_valid, resp_data); else n_pass++;
    end
    resp_ready = 4'b0100;
    tick(); #1;
    n_checks++; if (resp_valid !== 4'b0000) $display("FAIL resp_release: got %b want 0000", resp_valid); else n_pass++;
    n_checks++; if (err_bad_tid !== 1'b0)   $display("FAIL resp_err_clean: got %b want 0", err_bad_tid); else n_pass++;
    resp_ready = '0;
    // outstanding count for requester 2 is now zero, so another TID=2 response must be dropped
    push({16'd2, 32'h66});
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      n_checks++; if (resp_valid !== 4'b0000) $display("FAIL zero_cnt_drop c%0d: got %b want 0000", k, resp_valid); else n_pass++;
    end
    n_checks++; if (err_bad_tid !== 1'b1) $display("FAIL zero_cnt_err: got %b want 1", err_bad_tid); else n_pass++;
  endtask

  task automatic test_bad_tid();
    do_reset();
    n_checks++; if (err_bad_tid !== 1'b0) $display("FAIL bad_err_cleared: got %b want 0", err_bad_tid); else n_pass++;
    req_valid = 4'b1111;
    #1 tick();
    #1 tick();
    req_valid = '0;
    push({16'd7, 32'hDEAD});
    push({16'h0101, 32'h77});
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      n_checks++; if (resp_valid !== 4'b0000) $display("FAIL bad_no_resp c%0d: got %b want 0000", k, resp_valid); else n_pass++;
    end
    n_checks++; if (err_bad_tid !== 1'b1) $display("FAIL bad_err_set: got %b want 1", err_bad_tid); else n_pass++;
    repeat (3) tick();
    #1;
    n_checks++; if (err_bad_tid !== 1'b1) $display("FAIL bad_err_sticky: got %b want 1", err_bad_tid); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int w;
      logic [N-1:0] exp_rv;
      req_valid  = N'($urandom);
      resp_ready = N'($urandom);
      fifo_full  = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) req_payload[i*REQ_W +: REQ_W] = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 19) == 0) begin
          push({16'(4 + $urandom_range(0, 300)), $urandom});
        end else begin
          int st = $urandom_range(0, N - 1);
          for (int k = 0; k < N; k++) begin
            int i = (st + k) % N;
            int pend = 0;
            foreach (sq[j]) if (int'(sq[j][VPI_DATA_W-1:DATA_W]) == i) pend++;
            if (m_busy && int'(m_ent[VPI_DATA_W-1:DATA_W]) == i) pend++;
            if (m_cnt[i] > pend) begin
              push({16'(i), $urandom});
              break;
            end
          end
        end
      end
      #1;
      w = exp_winner();
      exp_rv = m_deliv ? (4'b0001 << m_ent[DATA_W+1:DATA_W]) : 4'b0000;
      n_checks++; if (req_ready !== ((w >= 0) ? (4'b0001 << w) : 4'b0000))
        $display("FAIL rnd_ready c%0d: got %b want winner %0d", c, req_ready, w); else n_pass++;
      n_checks++; if (fifo_wr_en !== (w >= 0))
        $display("FAIL rnd_wr_en c%0d: got %b want %b", c, fifo_wr_en, (w >= 0)); else n_pass++;
      if (w >= 0) begin
        n_checks++; if (fifo_wr_data !== {16'(w), req_payload[w*REQ_W +: REQ_W]})
          $display("FAIL rnd_wr_data c%0d: got %h want %h", c, fifo_wr_data, {16'(w), req_payload[w*REQ_W +: REQ_W]}); else n_pass++;
      end
      n_checks++; if (fifo_rd_en !== (!m_busy && sq.size() != 0))
        $display("FAIL rnd_rd_en c%0d: got %b want %b", c, fifo_rd_en, (!m_busy && sq.size() != 0)); else n_pass++;
      n_checks++; if (resp_valid !== exp_rv)
        $display("FAIL rnd_resp_valid c%0d: got %b want %b", c, resp_valid, exp_rv); else n_pass++;
      if (m_deliv) begin
        n_checks++; if (resp_data !== m_ent[DATA_W-1:0])
          $display("FAIL rnd_resp_data c%0d: got %h want %h", c, resp_data, m_ent[DATA_W-1:0]); else n_pass++;
      end
      n_checks++; if (err_bad_tid !== m_err)
        $display("FAIL rnd_err c%0d: got %b want %b", c, err_bad_tid, m_err); else n_pass++;
      tick();
    end
    req_valid = '0; resp_ready = '0; fifo_full = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_valid = 4'b0001;
    repeat (4) begin #1 tick(); end
    req_valid = 4'b1000;
    #1 tick();
    req_valid = 4'b1111;
    push({16'd3, 32'h99});
    tick(); tick();
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (req_ready !== '0)     $display("FAIL mid_req_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (fifo_wr_en !== 1'b0)  $display("FAIL mid_wr_en: got %b want 0", fifo_wr_en); else n_pass++;
    n_checks++; if (fifo_wr_data !== '0)  $display("FAIL mid_wr_data: got %h want 0", fifo_wr_data); else n_pass++;
    n_checks++; if (fifo_rd_en !== 1'b0)  $display("FAIL mid_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
    n_checks++; if (resp_valid !== '0)    $display("FAIL mid_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== '0)     $display("FAIL mid_resp_data: got %h want 0", resp_data); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (fifo_rd_en !== 1'b0 || resp_valid !== '0)
        $display("FAIL post_rst_idle c%0d: got rd_en %b resp_valid %b want 0/0", k, fifo_rd_en, resp_valid); else n_pass++;
      tick();
    end
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL post_rst_cnt_cleared: got %b want 0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
  endtask

  initial begin
    req_valid = '0; resp_ready = '0; fifo_full = 1'b0; fifo_empty = 1'b1;
    req_payload = '0; fifo_rd_data = '0; rst = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_issue_limit();
    test_round_robin();
    test_fifo_full();
    test_response();
    test_bad_tid();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
